// File: rtl/nes_video_pkg.sv
// nes_video_pkg -- shared types for the NES video path.
//   rgb15_t     : packed {B5,G5,R5} color word
//   PAL_ENTRIES : number of palette entries (one per 6-bit NES color index)
//   pal_state_t : palette download FSM states
package nes_video_pkg;

  typedef logic [14:0] rgb15_t;

  localparam int PAL_ENTRIES = 64;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LO   = 3'd1,
    HI   = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } pal_state_t;

endpackage

// File: rtl/nes_palette_ctrl.sv
// nes_palette_ctrl -- palette lookup and custom palette download controller
// for an external single-port synchronous palette RAM (1-cycle read latency).
//
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   pix_ce, color       : lookup strobe (<= once per 2 cycles) and color index
//   pix_rgb, pix_valid  : looked-up color, valid pulse two cycles after pix_ce
//   dl_start            : restart a custom palette download
//   dl_valid, dl_data   : download byte stream (LO byte, then HI byte per entry)
//   dl_ready            : byte handshake ready (LO/HI states only)
//   dl_done             : one-cycle pulse after the last entry is written
//   custom_active       : RAM holds a complete custom palette
//   ram_addr/we/wdata   : RAM request, ram_rdata: RAM read data
//   pal_csum            : (PAL_CHECKSUM_EN only) mod-2^16 sum of written words
//
// Optional feature macro: PAL_CHECKSUM_EN adds the pal_csum output.
module nes_palette_ctrl
  import nes_video_pkg::*;
#(
  parameter int ENTRIES = PAL_ENTRIES
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pix_ce,
  input  logic [5:0]  color,
  output rgb15_t      pix_rgb,
  output logic        pix_valid,
  input  logic        dl_start,
  input  logic        dl_valid,
  input  logic [7:0]  dl_data,
  output logic        dl_ready,
  output logic        dl_done,
  output logic        custom_active,
  output logic [5:0]  ram_addr,
  output logic        ram_we,
  output rgb15_t      ram_wdata,
  input  rgb15_t      ram_rdata
`ifdef PAL_CHECKSUM_EN
  ,
  output logic [15:0] pal_csum
`endif
);

  localparam logic [5:0] LAST = 6'(ENTRIES - 1);

  pal_state_t state;
  logic [5:0] wr_addr;
  logic [7:0] lo_byte;
  rgb15_t     word_q;
  // vld_pipe[1]: RAM read issued last cycle; vld_pipe[2]: pix_rgb just updated
  logic [2:1] vld_pipe;
  logic       accept;
  logic       wr_go;

  assign accept    = dl_valid && dl_ready;
  // A lookup steals the RAM port; the pending write simply waits in WR.
  assign wr_go     = (state == WR) && !pix_ce;
  assign pix_valid = vld_pipe[2];

  always_comb begin
    dl_ready  = (state == LO) || (state == HI);
    ram_we    = wr_go;
    ram_wdata = word_q;
    if (!reset_n)    ram_addr = '0;
    else if (pix_ce) ram_addr = color;
    else             ram_addr = wr_addr;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      wr_addr       <= '0;
      lo_byte       <= '0;
      word_q        <= '0;
      vld_pipe      <= '0;
      pix_rgb       <= '0;
      dl_done       <= 1'b0;
      custom_active <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[1], pix_ce};
      if (vld_pipe[1]) pix_rgb <= ram_rdata;
      dl_done <= 1'b0;

      if (dl_start) begin
        // Restart wins over any byte handshake this cycle; a half-built word
        // is dropped because LO overwrites lo_byte before it is used again.
        state         <= LO;
        wr_addr       <= '0;
        custom_active <= 1'b0;
      end else begin
        unique case (state)
          IDLE: ;
          LO: if (accept) begin
            lo_byte <= dl_data;
            state   <= HI;
          end
          HI: if (accept) begin
            word_q <= {dl_data[6:0], lo_byte};
            state  <= WR;
          end
          WR: if (wr_go) begin
            if (wr_addr == LAST) begin
              wr_addr       <= '0;
              state         <= DONE;
              dl_done       <= 1'b1;
              custom_active <= 1'b1;
            end else begin
              wr_addr <= wr_addr + 6'd1;
              state   <= LO;
            end
          end
          DONE: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef PAL_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      pal_csum <= '0;
    else if (dl_start) pal_csum <= '0;
    else if (wr_go)    pal_csum <= pal_csum + {1'b0, word_q};
  end
`endif

endmodule

// File: tb/tb_nes_palette_ctrl.sv
// tb_nes_palette_ctrl -- directed + randomized bench for nes_palette_ctrl.
// Reference palette is the words[] array; the RAM is a behavioural model.
// Build with PAL_CHECKSUM_EN to also cover pal_csum.
module tb_nes_palette_ctrl;
  import nes_video_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pix_ce = 1'b0;
  logic [5:0]  color = '0;
  logic [14:0] pix_rgb;
  logic        pix_valid;
  logic        dl_start = 1'b0;
  logic        dl_valid = 1'b0;
  logic [7:0]  dl_data = '0;
  logic        dl_ready, dl_done, custom_active;
  logic [5:0]  ram_addr;
  logic        ram_we;
  logic [14:0] ram_wdata;
  logic [14:0] ram_rdata;
`ifdef PAL_CHECKSUM_EN
  logic [15:0] pal_csum;
`endif

  nes_palette_ctrl #(.ENTRIES(64)) dut (
    .clk(clk), .reset_n(reset_n),
    .pix_ce(pix_ce), .color(color), .pix_rgb(pix_rgb), .pix_valid(pix_valid),
    .dl_start(dl_start), .dl_valid(dl_valid), .dl_data(dl_data),
    .dl_ready(dl_ready), .dl_done(dl_done), .custom_active(custom_active),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
`ifdef PAL_CHECKSUM_EN
    .pal_csum(pal_csum),
`endif
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Single-port synchronous RAM model; entry 5 preloaded during reset.
  logic [14:0] mem [64];
  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 64; i++) mem[i] <= (i == 5) ? 15'h1234 : 15'h0;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  // Reference palette and download bookkeeping.
  logic [14:0] words [64];
  int  exp_wr_idx = 0;
  int  wr_seen = 0;
  int  done_cnt = 0;
  bit  early_active = 0;

  // Every write must hit the next sequential entry with the reference word.
  always @(negedge clk) begin
    if (reset_n && ram_we) begin
      check("wr_addr", {26'd0, ram_addr}, exp_wr_idx % 64);
      check("wr_data", {17'd0, ram_wdata}, {17'd0, words[exp_wr_idx % 64]});
      exp_wr_idx++;
      wr_seen++;
    end
  end

  // pix_valid must echo pix_ce exactly two cycles later.
  always @(negedge clk or negedge reset_n) begin
    logic h1, h2;
    if (!reset_n) begin
      h1 = 1'b0;
      h2 = 1'b0;
    end else begin
      check("pix_valid_lat", {31'd0, pix_valid}, {31'd0, h2});
      h2 = h1;
      h1 = pix_ce;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample_status();
    if (dl_done) done_cnt++;
    if (custom_active && done_cnt == 0) early_active = 1;
  endtask

  // Send stop_bytes bytes of words[] with random gaps and random lookups.
  // collide_idx >= 0 forces a lookup in the WR cycle of that entry.
  task automatic do_load(input int stop_bytes, input int collide_idx);
    int bi = 0;
    int cyc = 0;
    bit last_ce = 0;
    bit force_ce = 0;
    bit chk_next = 0;
    bit acc;
    dl_start = 1; dl_valid = 0; pix_ce = 0;
    exp_wr_idx = 0; wr_seen = 0; done_cnt = 0; early_active = 0;
    tick();
    dl_start = 0;
    sample_status();
    while (bi < stop_bytes && cyc < 4000) begin
      dl_valid = ($urandom_range(3) != 0);
      if (bi % 2 == 0) dl_data = words[bi / 2][7:0];
      else             dl_data = {1'($urandom_range(1)), words[bi / 2][14:8]};
      color = 6'($urandom_range(63));
      if (force_ce) pix_ce = 1;
      else if (bi % 2 == 1 && bi / 2 == collide_idx) pix_ce = 0;
      else pix_ce = !last_ce && ($urandom_range(2) == 0);
      #1;
      if (force_ce) begin
        check("collide_we", {31'd0, ram_we}, 0);
        check("collide_raddr", {26'd0, ram_addr}, {26'd0, color});
        chk_next = 1;
      end else if (chk_next) begin
        check("retry_we", {31'd0, ram_we}, 1);
        check("retry_addr", {26'd0, ram_addr}, collide_idx);
        chk_next = 0;
      end
      force_ce = 0;
      acc = dl_valid && dl_ready;
      if (acc && bi % 2 == 1 && bi / 2 == collide_idx) force_ce = 1;
      last_ce = pix_ce;
      if (acc) bi++;
      tick();
      sample_status();
      cyc++;
    end
    if (cyc >= 4000) check("load_timeout", cyc, 0);
    dl_valid = 0;
    pix_ce = 0;
    if (stop_bytes == 128) begin
      cyc = 0;
      while (done_cnt == 0 && cyc < 20) begin
        tick();
        sample_status();
        cyc++;
      end
      repeat (3) begin
        tick();
        sample_status();
      end
    end else begin
      repeat (2) tick();
    end
  endtask

  task automatic lookup(input int c);
    pix_ce = 1; color = 6'(c);
    tick();
    pix_ce = 0;
    tick();
    check("lookup_valid", {31'd0, pix_valid}, 1);
    check("lookup_rgb", {17'd0, pix_rgb}, {17'd0, words[c]});
    tick();
  endtask

  function automatic logic [15:0] csum_model();
    int s = 0;
    for (int i = 0; i < 64; i++) s += words[i];
    return 16'(s);
  endfunction

  initial begin
    int diffs;
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_pix_rgb", {17'd0, pix_rgb}, 0);
    check("rst_pix_valid", {31'd0, pix_valid}, 0);
    check("rst_dl_done", {31'd0, dl_done}, 0);
    check("rst_custom", {31'd0, custom_active}, 0);
    check("rst_ram_we", {31'd0, ram_we}, 0);
    check("rst_ram_addr", {26'd0, ram_addr}, 0);
    check("rst_dl_ready", {31'd0, dl_ready}, 0);
    reset_n = 1;
    tick();

    // Lookup of preloaded entry 5: valid in N+2
    pix_ce = 1; color = 6'h05;
    #1;
    check("rd_addr", {26'd0, ram_addr}, 5);
    check("rd_we", {31'd0, ram_we}, 0);
    tick();
    pix_ce = 0;
    check("rd_n1_valid", {31'd0, pix_valid}, 0);
    tick();
    check("rd_n2_valid", {31'd0, pix_valid}, 1);
    check("rd_n2_rgb", {17'd0, pix_rgb}, 15'h1234);
    tick();
    check("rd_n3_valid", {31'd0, pix_valid}, 0);

    // Full load of 0x0000..0x003F with a lookup colliding on entry 10
    for (int i = 0; i < 64; i++) words[i] = 15'(i);
    do_load(128, 10);
    check("ld1_done_cnt", done_cnt, 1);
    check("ld1_active", {31'd0, custom_active}, 1);
    check("ld1_writes", wr_seen, 64);
    check("ld1_ram63", {17'd0, mem[63]}, 15'h003F);
    diffs = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== words[i]) diffs++;
    check("ld1_ram_all", diffs, 0);
`ifdef PAL_CHECKSUM_EN
    check("ld1_csum", {16'd0, pal_csum}, {16'd0, csum_model()});
`endif
    lookup(10);
    lookup(63);

    // Abort after 40 bytes, then full random load
    for (int i = 0; i < 64; i++) words[i] = 15'($urandom);
    do_load(40, -1);
    check("abort_active", {31'd0, custom_active}, 0);
    check("abort_writes", wr_seen, 20);
    do_load(128, -1);
    check("ld2_early_active", {31'd0, early_active}, 0);
    check("ld2_done_cnt", done_cnt, 1);
    check("ld2_active", {31'd0, custom_active}, 1);
    check("ld2_writes", wr_seen, 64);
`ifdef PAL_CHECKSUM_EN
    check("ld2_csum", {16'd0, pal_csum}, {16'd0, csum_model()});
`endif
    for (int k = 0; k < 6; k++) lookup($urandom_range(63));

    // Reset while waiting for a HI byte
    do_load(1, -1);
    check("hi_ready", {31'd0, dl_ready}, 1);
    #2;
    reset_n = 0;
    #1;
    check("mid_pix_rgb", {17'd0, pix_rgb}, 0);
    check("mid_pix_valid", {31'd0, pix_valid}, 0);
    check("mid_dl_done", {31'd0, dl_done}, 0);
    check("mid_custom", {31'd0, custom_active}, 0);
    check("mid_ram_we", {31'd0, ram_we}, 0);
    check("mid_ram_addr", {26'd0, ram_addr}, 0);
    check("mid_dl_ready", {31'd0, dl_ready}, 0);
    tick();
    reset_n = 1;
    tick();
    check("post_rst_ready", {31'd0, dl_ready}, 0);
    check("post_rst_active", {31'd0, custom_active}, 0);

`ifdef PAL_CHECKSUM_EN
    for (int i = 0; i < 64; i++) words[i] = 15'h7FFF;
    do_load(128, -1);
    check("csum_7fff", {16'd0, pal_csum}, 32'h0000FFC0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
